// File: rtl/rf_pkg.sv
// Shared constants for the 16 x 32-bit ARM-style register file.
// Also holds the bit offsets of the packed RSLCT register-select word.
`timescale 1ns/1ps
package rf_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int NREGS   = 2 ** ADDR_W;
    localparam int PC_IDX  = 15;
    localparam int RSLCT_W = 5 * ADDR_W;

    // Low bit of each select field inside RSLCT
    localparam int RSLCT_RN_IR = 0;
    localparam int RSLCT_RM    = 4;
    localparam int RSLCT_RS    = 8;
    localparam int RSLCT_RD    = 12;
    localparam int RSLCT_RN_CU = 16;

    function automatic logic [ADDR_W-1:0] rslct_field(input logic [RSLCT_W-1:0] rslct,
                                                      input int off);
        return rslct[off +: ADDR_W];
    endfunction
endpackage

// File: rtl/register_file_if.sv
// Control/operand bundle between the control unit/IR, the register file and the ALU.
// There is no valid/ready handshake: the controller holds RSLCT/in/Pcin/LOAD/LOADPC stable before each rising Clk.
`timescale 1ns/1ps
interface register_file_if;
    import rf_pkg::*;

    logic [DATA_W-1:0]  in;
    logic [DATA_W-1:0]  Pcin;
    logic [RSLCT_W-1:0] RSLCT;
    logic               LOADPC;
    logic               LOAD;
    logic               IR_CU;
    logic [DATA_W-1:0]  Rn;
    logic [DATA_W-1:0]  Rm;
    logic [DATA_W-1:0]  Rs;
    logic [DATA_W-1:0]  PCout;

    modport master (
        output in, Pcin, RSLCT, LOADPC, LOAD, IR_CU,
        input  Rn, Rm, Rs, PCout
    );

    modport slave (
        input  in, Pcin, RSLCT, LOADPC, LOAD, IR_CU,
        output Rn, Rm, Rs, PCout
    );
endinterface

// File: rtl/rf_reg.sv
// One register of the file: asynchronous active-low clear, synchronous load enable.
`timescale 1ns/1ps
module rf_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/register_file.sv
// 16 x 32-bit register file: three combinational read ports, one Rd write port and a PC load path into R15.
// Reads see the pre-edge contents; there is deliberately no write-through bypass.
`timescale 1ns/1ps
module register_file
    import rf_pkg::*;
(
    input  logic           Clk,
    input  logic           RESET,
    register_file_if.slave bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] rn_addr;
    logic [ADDR_W-1:0] rm_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rd_addr;

    assign rn_addr = bus.IR_CU ? rslct_field(bus.RSLCT, RSLCT_RN_CU)
                               : rslct_field(bus.RSLCT, RSLCT_RN_IR);
    assign rm_addr = rslct_field(bus.RSLCT, RSLCT_RM);
    assign rs_addr = rslct_field(bus.RSLCT, RSLCT_RS);
    assign rd_addr = rslct_field(bus.RSLCT, RSLCT_RD);

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic              en;
        logic [DATA_W-1:0] d;

        if (i == PC_IDX) begin : g_pc
            // LOADPC takes priority over an Rd=15 write in the same cycle
            assign en = bus.LOADPC | (bus.LOAD & (rd_addr == ADDR_W'(i)));
            assign d  = bus.LOADPC ? bus.Pcin : bus.in;
        end else begin : g_gp
            assign en = bus.LOAD & (rd_addr == ADDR_W'(i));
            assign d  = bus.in;
        end

        rf_reg #(.W(DATA_W)) u_reg (
            .clk   (Clk),
            .rst_n (RESET),
            .en    (en),
            .d     (d),
            .q     (regs[i])
        );
    end

    assign bus.Rn    = regs[rn_addr];
    assign bus.Rm    = regs[rm_addr];
    assign bus.Rs    = regs[rs_addr];
    assign bus.PCout = regs[PC_IDX];
endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against an array model of the 16 registers.
`timescale 1ns/1ps
module tb_register_file;
    import rf_pkg::*;

    logic Clk;
    logic RESET;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] model [NREGS];

    register_file_if bus ();

    register_file dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int rn_ir, input int rm, input int rs, input int rd, input int rn_cu);
        bus.RSLCT = {4'(rn_cu), 4'(rd), 4'(rs), 4'(rm), 4'(rn_ir)};
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Apply the architectural write rules to the model, then take one rising edge
    task automatic tick();
        int rd;
        rd = int'(bus.RSLCT[15:12]);
        if (RESET) begin
            if (bus.LOAD && rd != PC_IDX) model[rd] = bus.in;
            if (bus.LOADPC) model[PC_IDX] = bus.Pcin;
            else if (bus.LOAD && rd == PC_IDX) model[PC_IDX] = bus.in;
        end
        @(posedge Clk);
        #1;
    endtask

    // Walk all 16 addresses on every read port; only call when no write can occur
    task automatic check_all(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            bus.IR_CU = 1'b0;
            set_sel(i, i, i, 0, 0);
            #1;
            chk($sformatf("%s_rn%0d", tag, i), bus.Rn, model[i]);
            chk($sformatf("%s_rm%0d", tag, i), bus.Rm, model[i]);
            chk($sformatf("%s_rs%0d", tag, i), bus.Rs, model[i]);
        end
        chk({tag, "_pcout"}, bus.PCout, model[PC_IDX]);
    endtask

    task automatic check_ports(input string tag);
        int rn;
        rn = bus.IR_CU ? int'(bus.RSLCT[19:16]) : int'(bus.RSLCT[3:0]);
        chk({tag, "_rn"}, bus.Rn, model[rn]);
        chk({tag, "_rm"}, bus.Rm, model[int'(bus.RSLCT[7:4])]);
        chk({tag, "_rs"}, bus.Rs, model[int'(bus.RSLCT[11:8])]);
        chk({tag, "_pc"}, bus.PCout, model[PC_IDX]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();

        // Reset held low while both loads are requested and the clock runs
        RESET     = 1'b0;
        bus.LOAD   = 1'b1;
        bus.LOADPC = 1'b1;
        bus.IR_CU  = 1'b0;
        bus.in     = 32'hFFFF_FFFF;
        bus.Pcin   = 32'hFFFF_FFFF;
        set_sel(3, 3, 3, 3, 3);
        repeat (3) tick();
        check_ports("rst_loads_on");
        check_all("rst");

        // PC load, then hold when LOADPC drops
        RESET      = 1'b1;
        bus.LOAD   = 1'b0;
        bus.LOADPC = 1'b1;
        bus.Pcin   = 32'd1;
        tick();
        chk("pc_load", bus.PCout, 32'd1);
        bus.LOADPC = 1'b0;
        bus.Pcin   = 32'd2;
        tick();
        chk("pc_hold", bus.PCout, 32'd1);

        // Rd=3 write; old value visible until the edge
        bus.LOAD = 1'b1;
        bus.in   = 32'hDEAD_BEEF;
        set_sel(0, 3, 3, 3, 0);
        #1;
        chk("no_bypass_rm", bus.Rm, 32'd0);
        tick();
        bus.LOAD = 1'b0;
        chk("wr3_rm", bus.Rm, 32'hDEAD_BEEF);
        chk("wr3_rs", bus.Rs, 32'hDEAD_BEEF);
        chk("wr3_r0", bus.Rn, 32'd0);

        // Rn source select between IR and CU fields
        bus.LOAD = 1'b1;
        bus.in   = 32'h55;
        set_sel(3, 0, 0, 5, 5);
        tick();
        bus.LOAD  = 1'b0;
        bus.IR_CU = 1'b0;
        #1;
        chk("rn_ir", bus.Rn, 32'hDEAD_BEEF);
        bus.IR_CU = 1'b1;
        #1;
        chk("rn_cu", bus.Rn, 32'h55);
        bus.IR_CU = 1'b0;

        // LOAD to R15 collides with LOADPC: Pcin wins
        bus.LOAD   = 1'b1;
        bus.LOADPC = 1'b1;
        bus.in     = 32'h100;
        bus.Pcin   = 32'h200;
        set_sel(15, 15, 15, 15, 0);
        tick();
        bus.LOAD   = 1'b0;
        bus.LOADPC = 1'b0;
        chk("pc_prio_pcout", bus.PCout, 32'h200);
        chk("pc_prio_rn15", bus.Rn, 32'h200);

        // LOAD to another Rd alongside LOADPC: both land
        bus.LOAD   = 1'b1;
        bus.LOADPC = 1'b1;
        bus.in     = 32'h1234_5678;
        bus.Pcin   = 32'h300;
        set_sel(9, 9, 15, 9, 0);
        tick();
        bus.LOAD   = 1'b0;
        bus.LOADPC = 1'b0;
        chk("dual_r9", bus.Rm, 32'h1234_5678);
        chk("dual_pc", bus.Rs, 32'h300);

        // Mid-cycle async reset clears immediately
        bus.LOAD = 1'b1;
        bus.in   = 32'h77;
        set_sel(7, 7, 7, 7, 7);
        tick();
        bus.LOAD = 1'b0;
        chk("r7_written", bus.Rm, 32'h77);
        #2;
        RESET = 1'b0;
        model_clear();
        #1;
        chk("async_r7", bus.Rm, 32'd0);
        chk("async_pc", bus.PCout, 32'd0);
        check_all("async");
        RESET = 1'b1;
        @(posedge Clk);
        #1;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.LOAD   = 1'($urandom_range(0, 1));
            bus.LOADPC = ($urandom_range(0, 3) == 0);
            bus.IR_CU  = 1'($urandom_range(0, 1));
            bus.in     = $urandom;
            bus.Pcin   = $urandom;
            bus.RSLCT  = 20'($urandom);
            #1;
            check_ports("rnd_pre");
            if ($urandom_range(0, 49) == 0) begin
                RESET = 1'b0;
                model_clear();
                #1;
                check_ports("rnd_rst");
                tick();
                check_ports("rnd_rst_edge");
                RESET = 1'b1;
            end else begin
                tick();
                check_ports("rnd_post");
            end
        end

        bus.LOAD   = 1'b0;
        bus.LOADPC = 1'b0;
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
